// File: rtl/note_pkg.sv
// -----------------------------------------------------------------------------
// note_pkg
// Shared definitions for the frequency-to-note converter:
//   - table geometry (37 entries, 6-bit index)
//   - silence code and octave codes
//   - FSM state encoding
//   - 14-bit unsigned frequency type and an absolute-difference helper
// -----------------------------------------------------------------------------
package note_pkg;

    localparam int TABLE_SIZE = 37;
    localparam int FREQ_W     = 14;
    localparam int IDX_W      = 6;

    typedef logic [FREQ_W-1:0] freq_t;
    typedef logic [IDX_W-1:0]  idx_t;
    typedef logic [3:0]        note_t;
    typedef logic [2:0]        octave_t;

    localparam idx_t    LAST_IDX     = idx_t'(TABLE_SIZE - 1);
    localparam note_t   NOTE_SILENCE = 4'd13;

    // Octave codes are not ordered numerically: the lowest octave is 2.
    localparam octave_t OCT_C1 = 3'd2;
    localparam octave_t OCT_C2 = 3'd0;
    localparam octave_t OCT_C3 = 3'd1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Unsigned |a - b| without wrap-around.
    function automatic freq_t abs_diff(input freq_t a, input freq_t b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/freq_to_note_if.sv
// -----------------------------------------------------------------------------
// freq_to_note_if
// Request/result bundle of the frequency-to-note converter.
//   start     : request a conversion (master -> slave)
//   frequency : unsigned Hz value, captured on the accepted start
//   busy      : conversion in progress, through the done cycle
//   done      : one-cycle completion pulse
//   note      : 0..12 semitone above C, 13 = silence
//   octave    : octave code (2 = C1, 0 = C2, 1 = C3 range)
//   exact     : matched table frequency equals the request
// -----------------------------------------------------------------------------
interface freq_to_note_if;
    import note_pkg::*;

    logic    start;
    freq_t   frequency;
    logic    busy;
    logic    done;
    note_t   note;
    octave_t octave;
    logic    exact;

    modport master (
        output start, frequency,
        input  busy, done, note, octave, exact
    );

    modport slave (
        input  start, frequency,
        output busy, done, note, octave, exact
    );

endinterface

// File: rtl/note_table_rom.sv
// -----------------------------------------------------------------------------
// note_table_rom
// Combinational lookup of the 37-entry ascending note table.
//   idx    : table index 0..36 (out-of-range returns silence / freq 0)
//   note   : semitone 0..12
//   octave : octave code of the entry
//   freq   : nominal entry frequency in Hz
// -----------------------------------------------------------------------------
module note_table_rom
    import note_pkg::*;
(
    input  idx_t    idx,
    output note_t   note,
    output octave_t octave,
    output freq_t   freq
);

    always_comb begin
        freq = '0;
        case (idx)
            6'd0:  freq = 14'd33;
            6'd1:  freq = 14'd35;
            6'd2:  freq = 14'd37;
            6'd3:  freq = 14'd39;
            6'd4:  freq = 14'd41;
            6'd5:  freq = 14'd44;
            6'd6:  freq = 14'd46;
            6'd7:  freq = 14'd49;
            6'd8:  freq = 14'd52;
            6'd9:  freq = 14'd55;
            6'd10: freq = 14'd58;
            6'd11: freq = 14'd62;
            6'd12: freq = 14'd65;
            6'd13: freq = 14'd69;
            6'd14: freq = 14'd73;
            6'd15: freq = 14'd78;
            6'd16: freq = 14'd82;
            6'd17: freq = 14'd87;
            6'd18: freq = 14'd92;
            6'd19: freq = 14'd98;
            6'd20: freq = 14'd104;
            6'd21: freq = 14'd110;
            6'd22: freq = 14'd117;
            6'd23: freq = 14'd123;
            6'd24: freq = 14'd131;
            6'd25: freq = 14'd139;
            6'd26: freq = 14'd147;
            6'd27: freq = 14'd156;
            6'd28: freq = 14'd165;
            6'd29: freq = 14'd175;
            6'd30: freq = 14'd185;
            6'd31: freq = 14'd196;
            6'd32: freq = 14'd208;
            6'd33: freq = 14'd220;
            6'd34: freq = 14'd233;
            6'd35: freq = 14'd247;
            6'd36: freq = 14'd262;
            default: freq = '0;
        endcase
    end

    // Each 12-entry block is one octave; the top C (idx 36) is note 12 of C3.
    always_comb begin
        note   = NOTE_SILENCE;
        octave = OCT_C2;
        if (idx < 6'd12) begin
            note   = note_t'(idx);
            octave = OCT_C1;
        end else if (idx < 6'd24) begin
            note   = note_t'(idx - 6'd12);
            octave = OCT_C2;
        end else if (idx <= LAST_IDX) begin
            note   = note_t'(idx - 6'd24);
            octave = OCT_C3;
        end
    end

endmodule

// File: rtl/freq_to_note.sv
// -----------------------------------------------------------------------------
// freq_to_note
// Finds the nearest table note to an input frequency by scanning the note
// table one index per cycle (IDLE -> SCAN -> DONE -> IDLE).
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high
//   bus   : freq_to_note_if.slave (start/frequency in; busy/done/note/
//           octave/exact out)
// Optional build macro FREQ_TO_NOTE_EARLY_EXIT_EN: stop scanning at the
// first index whose distance exceeds the best so far (the table ascends, so
// distances only grow from there). Without it the scan always covers all 37
// entries and done arrives 38 cycles after acceptance.
// -----------------------------------------------------------------------------
module freq_to_note
    import note_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    freq_to_note_if.slave      bus
);

    state_t  state_q,     state_d;
    idx_t    idx_q,       idx_d;
    freq_t   freq_q,      freq_d;
    freq_t   best_diff_q, best_diff_d;
    note_t   best_note_q, best_note_d;
    octave_t best_oct_q,  best_oct_d;
    logic    best_exact_q, best_exact_d;
    note_t   note_q,      note_d;
    octave_t octave_q,    octave_d;
    logic    exact_q,     exact_d;

    note_t   rom_note;
    octave_t rom_octave;
    freq_t   rom_freq;
    freq_t   diff;
    logic    better;
    logic    early_stop;

    note_table_rom u_rom (
        .idx    (idx_q),
        .note   (rom_note),
        .octave (rom_octave),
        .freq   (rom_freq)
    );

    assign diff   = abs_diff(freq_q, rom_freq);
    // Strictly smaller only, so ties keep the lower index.
    assign better = (diff < best_diff_q);

`ifdef FREQ_TO_NOTE_EARLY_EXIT_EN
    assign early_stop = (diff > best_diff_q);
`else
    assign early_stop = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        freq_d       = freq_q;
        best_diff_d  = best_diff_q;
        best_note_d  = best_note_q;
        best_oct_d   = best_oct_q;
        best_exact_d = best_exact_q;
        note_d       = note_q;
        octave_d     = octave_q;
        exact_d      = exact_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    freq_d      = bus.frequency;
                    idx_d       = '0;
                    // Max distance guarantees idx 0 always becomes the first best.
                    best_diff_d = '1;
                    state_d     = ST_SCAN;
                end
            end

            ST_SCAN: begin
                if (better) begin
                    best_diff_d  = diff;
                    best_note_d  = rom_note;
                    best_oct_d   = rom_octave;
                    best_exact_d = (diff == '0);
                end

                if ((idx_q == LAST_IDX) || early_stop) begin
                    state_d = ST_DONE;
                    // The final index may itself be the winner, so use the
                    // freshly computed best rather than the registered one.
                    if (freq_q == '0) begin
                        note_d   = NOTE_SILENCE;
                        octave_d = OCT_C2;
                        exact_d  = 1'b0;
                    end else begin
                        note_d   = best_note_d;
                        octave_d = best_oct_d;
                        exact_d  = best_exact_d;
                    end
                end else begin
                    idx_d = idx_q + 6'd1;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            freq_q       <= '0;
            best_diff_q  <= '0;
            best_note_q  <= '0;
            best_oct_q   <= '0;
            best_exact_q <= 1'b0;
            note_q       <= NOTE_SILENCE;
            octave_q     <= OCT_C2;
            exact_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            freq_q       <= freq_d;
            best_diff_q  <= best_diff_d;
            best_note_q  <= best_note_d;
            best_oct_q   <= best_oct_d;
            best_exact_q <= best_exact_d;
            note_q       <= note_d;
            octave_q     <= octave_d;
            exact_q      <= exact_d;
        end
    end

    assign bus.busy   = (state_q != ST_IDLE);
    assign bus.done   = (state_q == ST_DONE);
    assign bus.note   = note_q;
    assign bus.octave = octave_q;
    assign bus.exact  = exact_q;

endmodule

// File: tb/tb_freq_to_note.sv
module tb_freq_to_note;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    freq_to_note_if bus ();

    freq_to_note dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tbl_f [37] = '{33, 35, 37, 39, 41, 44, 46, 49, 52, 55, 58, 62,
                       65, 69, 73, 78, 82, 87, 92, 98, 104, 110, 117, 123,
                       131, 139, 147, 156, 165, 175, 185, 196, 208, 220, 233, 247, 262};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Nearest-entry search over the table in plain arithmetic.
    task automatic model(input int f, output int m_note, output int m_oct,
                         output int m_exact, output int m_dcyc);
        int best, bidx, d, stop_k;
        best   = 1 << 30;
        bidx   = 0;
        stop_k = 36;
        for (int k = 0; k < 37; k++) begin
            d = (f > tbl_f[k]) ? f - tbl_f[k] : tbl_f[k] - f;
`ifdef FREQ_TO_NOTE_EARLY_EXIT_EN
            if (d > best) begin
                stop_k = k;
                break;
            end
`endif
            if (d < best) begin
                best = d;
                bidx = k;
            end
        end
        m_dcyc = stop_k + 2;
        if (f == 0) begin
            m_note = 13; m_oct = 0; m_exact = 0;
        end else begin
            m_note  = (bidx == 36) ? 12 : bidx % 12;
            case (bidx / 12)
                0:       m_oct = 2;
                1:       m_oct = 0;
                default: m_oct = 1;
            endcase
            m_exact = (best == 0) ? 1 : 0;
        end
    endtask

    // Entered just after a falling edge (that cycle = cycle 0); returns just
    // after the falling edge of the cycle following done.
    task automatic run_conv(input int f, input bit repulse, input string tag);
        int en, eo, ee, ed, cyc;
        bit got, busy_ok;
        logic [3:0] held_note;
        model(f, en, eo, ee, ed);
        bus.start     = 1'b1;
        bus.frequency = 14'(f);
        @(negedge clk);
        cyc     = 1;
        got     = 0;
        busy_ok = 1;
        while (cyc <= 60) begin
            if (bus.busy !== 1'b1) busy_ok = 0;
            if (bus.done === 1'b1) begin
                got = 1;
                break;
            end
            if (repulse && (cyc == 5 || cyc == 20)) begin
                bus.start     = 1'b1;
                bus.frequency = 14'd33;
            end else begin
                bus.start     = 1'b0;
                bus.frequency = 14'($urandom_range(0, 16383));
            end
            @(negedge clk);
            cyc++;
        end
        bus.start = 1'b0;
        check({tag, "_done_seen"}, 32'(got), 32'd1);
        check({tag, "_done_cycle"}, 32'(cyc), 32'(ed));
        check({tag, "_busy_span"}, 32'(busy_ok), 32'd1);
        check({tag, "_note"}, 32'(bus.note), 32'(en));
        check({tag, "_octave"}, 32'(bus.octave), 32'(eo));
        check({tag, "_exact"}, 32'(bus.exact), 32'(ee));
        held_note = bus.note;
        @(negedge clk);
        check({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
        check({tag, "_busy_after"}, 32'(bus.busy), 32'd0);
        check({tag, "_note_hold"}, 32'(bus.note), 32'(held_note));
    endtask

    initial begin
        total         = 0;
        bad           = 0;
        reset         = 1'b1;
        bus.start     = 1'b0;
        bus.frequency = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_note", 32'(bus.note), 32'd13);
        check("rst_octave", 32'(bus.octave), 32'd0);
        check("rst_exact", 32'(bus.exact), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        run_conv(220, 1'b0, "f220");
        run_conv(100, 1'b0, "f100");
        run_conv(101, 1'b0, "f101_tie");
        run_conv(0, 1'b0, "f0");
        run_conv(5000, 1'b0, "f5000");
        run_conv(1, 1'b0, "f1");
        run_conv(34, 1'b0, "f34_tie");
        run_conv(262, 1'b0, "f262");
        run_conv(16383, 1'b0, "fmax");
        run_conv(220, 1'b1, "f220_repulse");

        for (int i = 0; i < 12; i++) begin
            if (i < 8) run_conv(int'($urandom_range(1, 300)), 1'b0, "rand_lo");
            else       run_conv(int'($urandom_range(0, 16383)), 1'b0, "rand_any");
        end

        // Reset in the middle of a scan, after a result other than silence.
        bus.start     = 1'b1;
        bus.frequency = 14'd220;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        #1;
        check("midrst_busy", 32'(bus.busy), 32'd0);
        check("midrst_note", 32'(bus.note), 32'd13);
        check("midrst_done", 32'(bus.done), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        run_conv(65, 1'b0, "after_rst_f65");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/freq_to_note.md
FREQ_TO_NOTE -- requirements
Module: freq_to_note

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock; all state on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port start, input, 1 bit: request a conversion; sampled only in IDLE.
REQ-004 SHALL have port frequency, input, 14 bits: unsigned Hz value, captured on the accepted start.
REQ-005 SHALL have port busy, output, 1 bit: high from acceptance until the done cycle, inclusive.
REQ-006 SHALL have port done, output, 1 bit: one-cycle pulse; result valid from this cycle on.
REQ-007 SHALL have port note, output, 4 bits: 0..12 = C..C (semitones); 13 = silence.
REQ-008 SHALL have port octave, output, 3 bits: 2 = C1 range, 0 = C2 range, 1 = C3 range.
REQ-009 SHALL have port exact, output, 1 bit: high when the matched table frequency equals the input.

Function
REQ-010 SHALL use a 37-entry ascending table:
- idx 0-11: octave 2, notes 0-11 = 33,35,37,39,41,44,46,49,52,55,58,62
- idx 12-23: octave 0, notes 0-11 = 65,69,73,78,82,87,92,98,104,110,117,123
- idx 24-36: octave 1, notes 0-12 = 131,139,147,156,165,175,185,196,208,220,233,247,262
REQ-011 SHALL implement the FSM IDLE -> SCAN -> DONE -> IDLE.
REQ-012 IDLE: start=1 captures frequency, sets busy and enters SCAN. Start in any other state SHALL be ignored.
REQ-013 SCAN SHALL evaluate one index per cycle. Idx n is evaluated in cycle n+1 after acceptance (acceptance edge = cycle 0).
REQ-014 Per index, SHALL compute the 14-bit unsigned |frequency - entry| and replace the best only if strictly smaller. Ties therefore resolve to the lower index.
REQ-015 After idx 36, SHALL enter DONE. done is high in cycle 38, and note/octave/exact update in that same cycle.
REQ-016 If the captured frequency is 0, SHALL output note=13, octave=0, exact=0, with the same latency.
REQ-017 Frequencies above 262 SHALL yield idx 36 (note 12, octave 1). Frequencies 1-33 SHALL yield idx 0.
REQ-018 note/octave/exact SHALL hold their values between done pulses.
REQ-019 DONE SHALL return to IDLE in the next cycle. A start in the cycle after done SHALL be accepted.

Reset
REQ-020 Reset SHALL force IDLE at any time, including mid-SCAN, and discard any partial search.
REQ-021 Reset values SHALL be: busy=0, done=0, note=13, octave=0, exact=0; internal index and best-diff cleared.

Configuration
REQ-022 With macro FREQ_TO_NOTE_EARLY_EXIT_EN defined:
- SCAN SHALL exit when the evaluated idx k has diff > best diff, or after idx 36.
- done then asserts in cycle k+2.
- Result values SHALL be identical to the full scan.
REQ-023 Without FREQ_TO_NOTE_EARLY_EXIT_EN, latency SHALL be fixed at 38 cycles per REQ-015.

Structure
REQ-024 A shared package note_pkg SHALL hold:
- table size (37)
- silence code (13)
- octave codes
- FSM state enum
- 14-bit frequency type
REQ-025 SHALL contain one sub-module, note_table_rom: combinational idx -> {note, octave, freq}.

Verification
REQ-026 frequency=220, start -> cycle 38: done=1, note=9, octave=1, exact=1. With EARLY_EXIT_EN: done in cycle 36.
REQ-027 frequency=100 -> note=7, octave=0, exact=0 (98 beats 104). frequency=101 (tie, diff 3) -> note=7, octave=0.
REQ-028 frequency=0 -> note=13, octave=0, exact=0, done in cycle 38. frequency=5000 -> note=12, octave=1, exact=0.
REQ-029 Start re-pulsed with frequency=33 at cycles 5 and 20 of a 220 conversion -> ignored; result still note=9, octave=1. Busy high from cycle 1 through cycle 38.
REQ-030 Reset asserted at cycle 10 of a conversion:
- Immediately: busy=0 and note=13.
- A subsequent start with frequency=65 -> note=0, octave=0, exact=1.
